// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, FSM states and
// opcode-class helpers used by both the stage and the ALU.
package alu_issue_stage_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_MOD  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NAND = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NOTA = 4'b1101;
  localparam logic [3:0] OP_ANDN = 4'b1110;
  localparam logic [3:0] OP_XNOR = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [3:0] sel);
    return (sel == OP_MUL) || (sel == OP_DIV) || (sel == OP_MOD);
  endfunction

  // 0101/0110/0111 are undefined arithmetic codes
  function automatic logic is_illegal(input logic [3:0] sel);
    return (sel == 4'b0101) || (sel == 4'b0110) || (sel == 4'b0111);
  endfunction

endpackage

// File: rtl/alu_32bit.sv
// Combinational 32-bit ALU with a 64-bit result. Logic results are
// sign-extended from bit 31; division by zero yields all-ones / the dividend.
module alu_32bit
  import alu_issue_stage_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  sel,
  output logic [63:0] alu_out
);

  logic [31:0] logic_s;

  // Bitwise operations, selected by the low opcode bits
  always_comb begin
    logic_s = 32'd0;
    case (sel[2:0])
      3'b000:  logic_s = a & b;
      3'b001:  logic_s = a | b;
      3'b010:  logic_s = a ^ b;
      3'b011:  logic_s = ~(a & b);
      3'b100:  logic_s = ~(a | b);
      3'b101:  logic_s = ~a;
      3'b110:  logic_s = a & ~b;
      3'b111:  logic_s = ~(a ^ b);
      default: logic_s = 32'd0;
    endcase
  end

  // Result mux across arithmetic and logic classes
  always_comb begin
    alu_out = 64'd0;
    case (sel)
      OP_ADD:  alu_out = {32'd0, a} + {32'd0, b};
      OP_SUB:  alu_out = {32'd0, a - b};
      OP_MUL:  alu_out = {32'd0, a} * {32'd0, b};
      OP_DIV:  alu_out = (b == 32'd0) ? {32'd0, 32'hFFFF_FFFF} : {32'd0, a / b};
      OP_MOD:  alu_out = (b == 32'd0) ? {32'd0, a} : {32'd0, a % b};
      default: alu_out = sel[3] ? {{32{logic_s[31]}}, logic_s} : 64'd0;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Valid/ready issue stage around alu_32bit: holds operands stable for a
// per-opcode settle time, then captures and presents the result.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int ARITH_WAIT  = 1,
  parameter int MULDIV_WAIT = 4,
  parameter int CNT_W       = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [3:0]  in_sel,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic [3:0]  res_sel,
  output logic        res_zero,
  output logic        res_illegal
);

  state_t             state_r;
  state_t             state_s;
  logic               accept_s;
  logic               capture_s;
  logic [31:0]        a_r;
  logic [31:0]        b_r;
  logic [3:0]         sel_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   wait_s;
  logic [63:0]        alu_out_s;
  logic [63:0]        clean_s;

  alu_32bit u_alu (
    .a       (a_r),
    .b       (b_r),
    .sel     (sel_r),
    .alu_out (alu_out_s)
  );

  assign wait_s = is_muldiv(in_sel) ? CNT_W'(MULDIV_WAIT) : CNT_W'(ARITH_WAIT);

  // Illegal codes collapse to zero; logic ops keep only the low word
  always_comb begin
    clean_s = alu_out_s;
    if (is_illegal(sel_r)) begin
      clean_s = 64'd0;
    end else if (sel_r[3]) begin
      clean_s = {32'd0, alu_out_s[31:0]};
    end else begin
      clean_s = alu_out_s;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode with accept/capture strobes
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (in_valid) begin
          accept_s = 1'b1;
          state_s  = S_BUSY;
        end else begin
          state_s  = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt_r == CNT_W'(1)) begin
          capture_s = 1'b1;
          state_s   = S_DONE;
        end else begin
          state_s   = S_BUSY;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Operand capture (only on accept, so the multicycle path stays static) and settle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r   <= 32'd0;
      b_r   <= 32'd0;
      sel_r <= 4'd0;
      cnt_r <= '0;
    end else if (accept_s) begin
      a_r   <= in_a;
      b_r   <= in_b;
      sel_r <= in_sel;
      cnt_r <= wait_s;
    end else if (state_r == S_BUSY) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end
  end

  // Registered result, flags and handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready    <= 1'b1;
      res_valid   <= 1'b0;
      res_data    <= 64'd0;
      res_sel     <= 4'd0;
      res_zero    <= 1'b0;
      res_illegal <= 1'b0;
    end else begin
      in_ready  <= (state_s == S_IDLE);
      res_valid <= (state_s == S_DONE);
      if (capture_s) begin
        res_data    <= clean_s;
        res_sel     <= sel_r;
        res_zero    <= (clean_s == 64'd0);
        res_illegal <= is_illegal(sel_r);
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed and table-driven bench for alu_issue_stage.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_sel;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic [3:0]  res_sel;
  logic        res_zero;
  logic        res_illegal;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_last = 0;
  int acc_gap = 0;

  alu_issue_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_sel      (in_sel),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_sel     (res_sel),
    .res_zero    (res_zero),
    .res_illegal (res_illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready && !rst) begin
      acc_gap  <= cyc - acc_last;
      acc_last <= cyc;
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [63:0] data;
    logic        zero;
    logic        ill;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_data(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] sel);
    logic [31:0] r;
    if (sel == 4'd5 || sel == 4'd6 || sel == 4'd7) return 64'd0;
    if (sel[3]) begin
      r = 32'd0;
      if (sel == 4'b1000) r = a & b;
      if (sel == 4'b1001) r = a | b;
      if (sel == 4'b1010) r = a ^ b;
      if (sel == 4'b1011) r = ~(a & b);
      if (sel == 4'b1100) r = ~(a | b);
      if (sel == 4'b1101) r = ~a;
      if (sel == 4'b1110) r = a & ~b;
      if (sel == 4'b1111) r = ~(a ^ b);
      return {32'd0, r};
    end
    if (sel == 4'd0) return 64'(a) + 64'(b);
    if (sel == 4'd1) return {32'd0, a - b};
    if (sel == 4'd2) return 64'(a) * 64'(b);
    if (sel == 4'd3) return (b == 32'd0) ? 64'h0000_0000_FFFF_FFFF : 64'(a / b);
    if (sel == 4'd4) return (b == 32'd0) ? 64'(a) : 64'(a % b);
    return 64'd0;
  endfunction

  task automatic run(input vec_t v, input string tag);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    chk({tag, " ready_before"}, 64'(in_ready), 64'd1);
    in_a = v.a; in_b = v.b; in_sel = v.sel; in_valid = 1'b1;
    res_ready = (v.hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = ~v.a; in_b = ~v.b; in_sel = ~v.sel;
    lat = 0;
    while (!res_valid && lat < 50) begin
      chk({tag, " alu_a_stable"}, 64'(dut.u_alu.a), 64'(v.a));
      chk({tag, " alu_b_stable"}, 64'(dut.u_alu.b), 64'(v.b));
      @(posedge clk); #1; lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(v.lat));
    chk({tag, " data"}, res_data, v.data);
    chk({tag, " zero"}, 64'(res_zero), 64'(v.zero));
    chk({tag, " illegal"}, 64'(res_illegal), 64'(v.ill));
    chk({tag, " sel"}, 64'(res_sel), 64'(v.sel));
    chk({tag, " ready_done"}, 64'(in_ready), 64'd0);
    repeat (v.hold) begin
      @(posedge clk); #1;
      chk({tag, " held_valid"}, 64'(res_valid), 64'd1);
      chk({tag, " held_data"}, res_data, v.data);
      chk({tag, " held_ready"}, 64'(in_ready), 64'd0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, " valid_after"}, 64'(res_valid), 64'd0);
    chk({tag, " ready_after"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    vec_t rv;
    logic [3:0] ops[14];
    int guard;
    vecs[0]  = '{32'd5310, 32'd112, 4'b0000, 64'd5422, 1'b0, 1'b0, 1, 0};
    vecs[1]  = '{32'd5310, 32'd112, 4'b0010, 64'd594720, 1'b0, 1'b0, 4, 0};
    vecs[2]  = '{32'hF0F0F0F0, 32'hFFFF0000, 4'b1010, 64'h0000_0000_0F0F_F0F0, 1'b0, 1'b0, 1, 5};
    vecs[3]  = '{32'd7, 32'd7, 4'b0001, 64'd0, 1'b1, 1'b0, 1, 0};
    vecs[4]  = '{32'd5, 32'd3, 4'b0110, 64'd0, 1'b1, 1'b1, 1, 1};
    vecs[5]  = '{32'd5310, 32'd112, 4'b0011, 64'd47, 1'b0, 1'b0, 4, 2};
    vecs[6]  = '{32'd5310, 32'd112, 4'b0100, 64'd46, 1'b0, 1'b0, 4, 0};
    vecs[7]  = '{32'hFFFFFFFF, 32'd1, 4'b0000, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1, 0};
    vecs[8]  = '{32'hFFFFFFFF, 32'h80000001, 4'b1000, 64'h0000_0000_8000_0001, 1'b0, 1'b0, 1, 0};
    vecs[9]  = '{32'h12345678, 32'h12345678, 4'b1111, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1, 0};
    vecs[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0101, 64'd0, 1'b1, 1'b1, 1, 0};
    vecs[11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0010, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b0, 4, 0};
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};

    rst = 1'b1; in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0; in_sel = 4'd0; res_ready = 1'b1;
    #1;
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst res_valid", 64'(res_valid), 64'd0);
    chk("rst res_data", res_data, 64'd0);
    chk("rst res_sel", 64'(res_sel), 64'd0);
    chk("rst res_zero", 64'(res_zero), 64'd0);
    chk("rst res_illegal", 64'(res_illegal), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset during the second BUSY cycle of a divide
    in_a = 32'd5310; in_b = 32'd112; in_sel = 4'b0011; in_valid = 1'b1; res_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst res_valid", 64'(res_valid), 64'd0);
    chk("midrst in_ready", 64'(in_ready), 64'd1);
    chk("midrst res_data", res_data, 64'd0);
    chk("midrst res_sel", 64'(res_sel), 64'd0);
    chk("midrst operand_a", 64'(dut.u_alu.a), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("midrst no_result", 64'(res_valid), 64'd0);
    end
    chk("midrst ready_after", 64'(in_ready), 64'd1);

    // Throughput with res_ready tied high and in_valid held
    in_a = 32'd1; in_b = 32'd2; in_sel = 4'b0000; res_ready = 1'b1; in_valid = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    chk("gap add", 64'(acc_gap), 64'd3);
    in_sel = 4'b0010;
    repeat (20) begin @(posedge clk); #1; end
    chk("gap mul", 64'(acc_gap), 64'd6);
    in_valid = 1'b0;
    guard = 0;
    while (!in_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    chk("drain ready", 64'(in_ready), 64'd1);

    // Random stream against the reference model
    for (int i = 0; i < 8; i++) begin
      rv.a    = $urandom;
      rv.b    = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 9)) : $urandom;
      rv.sel  = ops[$urandom_range(0, 13)];
      rv.data = ref_data(rv.a, rv.b, rv.sel);
      rv.zero = (rv.data == 64'd0);
      rv.ill  = (rv.sel == 4'd5);
      rv.lat  = (rv.sel == 4'd2 || rv.sel == 4'd3 || rv.sel == 4'd4) ? 4 : 1;
      rv.hold = $urandom_range(0, 3);
      run(rv, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
